action_input: RTL and testbench
===============================

# action_input

Input-side front end for the pet game. It takes the eight raw user switches/buttons (the `ui_in` lines), synchronizes and debounces them, and turns each press into a single action command. Commands go to the stats logic over a valid/ready handshake. The status/LED path drives the game state out to the user; this block carries user intent into the game, so the stats logic sees clean, one-shot actions instead of raw levels.

## Interface
Parameters:
- `DEBOUNCE_COUNT`, default 24'd50_000: length of one debounce sample period, in clock cycles (must be ≥ 2).

Ports:
- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `buttons`  input  8  raw asynchronous switch levels, active high; bit i = action i.
- `pressed`  output  8  debounced switch levels.
- `cmd_valid`  output  1  an action command is offered.
- `cmd_code`  output  3  index of the offered action (0–7).
- `cmd_ready`  input  1  consumer accepts the command when it is high together with `cmd_valid` at a rising edge.
- `dropped`  output  1  one-cycle pulse: a press was lost because that action was already pending.

## Operation
- **Synchronizer.** Each `buttons` bit passes through a 2-flop synchronizer. The result is `sync[i]`.
- **Prescaler.** A 24-bit counter runs 0..DEBOUNCE_COUNT-1 and wraps. `tick` is high during the cycle in which count == DEBOUNCE_COUNT-1.
- **Debounce.** Each bit has a 2-bit disagreement counter `dc[i]`, evaluated only on tick cycles:
  - If `sync[i]` != `pressed[i]`: increment `dc[i]`. If `dc[i]` was already 2, toggle `pressed[i]` and clear `dc[i]`. A level change therefore needs 3 consecutive disagreeing ticks.
  - If `sync[i]` == `pressed[i]`: clear `dc[i]`.
- **Edge detect.** `prev` is a registered copy of `pressed`. A rise is `pressed & ~prev`. Each rise on bit i sets `pending[i]` on the next edge. Releases generate nothing.
- **Drop.** If a rise occurs on bit i while `pending[i]` is already 1, `pending[i]` stays 1 and `dropped` pulses high for one cycle.
- **Command FSM, state IDLE.**
  - If `pending` != 0: select the lowest set index k, load `cmd_code`=k, set `cmd_valid`=1, clear `pending[k]`, and go to OFFER.
  - Otherwise stay in IDLE.
- **Command FSM, state OFFER.**
  - Hold `cmd_valid`=1 and keep `cmd_code` stable.
  - On an edge with `cmd_ready`=1, set `cmd_valid`=0 and go to IDLE.
  - `cmd_ready` has no effect while `cmd_valid`=0.
- **Simultaneous set/clear.** If IDLE clears `pending[k]` on the same edge that a new rise sets it, set wins: `pending[k]`=1 afterwards, no drop.
- **Rise during offer.** A rise on the bit currently being offered sets `pending` again. It is not a drop.
- **Arbitration.** Fixed priority, lowest index first. Lower actions held and re-pressed continuously can starve higher ones; this is accepted.

## Timing
- Reset values, asynchronous:
  - `pressed`=0, `cmd_valid`=0, `cmd_code`=0, `dropped`=0.
  - Synchronizers, `prev`, `pending`, all `dc`, prescaler = 0.
  - FSM = IDLE.
- Reset mid-handshake: the offer is abandoned and all pending commands are discarded.
- Press registration: after a `buttons` change, `pressed` changes between 2+2·N+1 and 2+3·N cycles later (N = DEBOUNCE_COUNT). It changes at the edge of the 3rd disagreeing tick.
- Glitch rejection: a `buttons` pulse shorter than 2·N cycles never changes `pressed`.
- Command latency: `cmd_valid` rises exactly 2 edges after the edge at which `pressed[i]` rises, provided the FSM is IDLE and nothing is pending.
- Throughput: at most one command per 2 cycles. Accept happens at edge t, and the next offer appears at edge t+1 at the earliest.
- `dropped` is high for exactly one cycle, aligned to the edge that would have set `pending`.

## Test plan
All scenarios use DEBOUNCE_COUNT=4.
1. **Reset.** Assert `rst_n`=0 mid-offer (`cmd_valid`=1). All outputs go to 0 immediately. After release, no command appears without a new press.
2. **Single press.** `buttons`=8'h04 held for 20 cycles, `cmd_ready`=1. `pressed[2]` rises within 11–14 cycles. `cmd_valid`=1 with `cmd_code`=2 exactly 2 edges later, for 1 cycle only. Releasing the button produces no command.
3. **Glitch rejection.** 7-cycle pulse on `buttons[5]`. `pressed` stays 0 and `cmd_valid` never rises.
4. **Backpressure and priority.** Raise `buttons`=8'h81 together with `cmd_ready`=0. Expect `cmd_valid`=1, `cmd_code`=0, held stable for 10 cycles. Pulse `cmd_ready`. The next offer is `cmd_code`=7, starting on the following edge.
5. **Drop.** `cmd_ready`=0 while offering action 3. Press and release action 1 twice. The first press sets pending, the second pulses `dropped` once. After acceptances, exactly two commands are seen: 3 then 1.
6. **Bounce.** `buttons[0]` toggles every 3 cycles for 30 cycles, then holds high. Exactly one command with `cmd_code`=0 results.

Source files
------------

// File: rtl/action_input_if.sv
// action_input_if
//   Valid/ready command channel from the input front end to the stats logic.
//   master (action_input): drives cmd_valid and cmd_code, samples cmd_ready.
//   slave  (stats logic):  samples cmd_valid and cmd_code, drives cmd_ready.
//   Signals:
//     cmd_valid - an action command is offered
//     cmd_code  - index of the offered action (0-7)
//     cmd_ready - consumer accepts when high together with cmd_valid at a rising edge
interface action_input_if;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready
  );
endinterface

// File: rtl/action_input.sv
// action_input
//   Pet-game input front end: synchronizes and debounces the eight raw user
//   switches and turns each debounced press into one action command offered
//   over a valid/ready channel.
//   Ports:
//     clk      - system clock, all state on the rising edge
//     rst_n    - asynchronous active-low reset
//     buttons  - raw asynchronous switch levels, active high, bit i = action i
//     pressed  - debounced switch levels
//     dropped  - one-cycle pulse when a press is lost (action already pending)
//     cmd      - command channel (master side): cmd_valid, cmd_code, cmd_ready
//   Parameter:
//     DEBOUNCE_COUNT - debounce sample period in clock cycles (>= 2)
module action_input #(
  parameter logic [23:0] DEBOUNCE_COUNT = 24'd50_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           buttons,
  output logic [7:0]           pressed,
  output logic                 dropped,
  action_input_if.master       cmd
);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [7:0]  sync1_q, sync2_q;
  logic [23:0] cnt_q, cnt_d;
  logic        tick;
  logic [1:0]  dc_q [8];
  logic [1:0]  dc_d [8];
  logic [7:0]  pressed_q, pressed_d;
  logic [7:0]  prev_q;
  logic [7:0]  rise;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  clr_mask;
  logic [2:0]  sel;
  logic        dropped_q, dropped_d;
  state_t      state_q;
  logic        valid_q;
  logic [2:0]  code_q;

  // Prescaler: one debounce sample per DEBOUNCE_COUNT cycles.
  assign tick  = (cnt_q == DEBOUNCE_COUNT - 24'd1);
  assign cnt_d = tick ? 24'd0 : cnt_q + 24'd1;

  // A level change needs three consecutive disagreeing ticks; the toggle
  // happens on the third one (counter already at 2).
  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < 8; i++) begin
      dc_d[i] = dc_q[i];
      if (tick) begin
        if (sync2_q[i] != pressed_q[i]) begin
          if (dc_q[i] == 2'd2) begin
            pressed_d[i] = ~pressed_q[i];
            dc_d[i]      = 2'd0;
          end else begin
            dc_d[i] = dc_q[i] + 2'd1;
          end
        end else begin
          dc_d[i] = 2'd0;
        end
      end
    end
  end

  assign rise = pressed_q & ~prev_q;

  // Lowest pending index wins.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) sel = 3'(i);
    end
  end

  assign clr_mask = ((state_q == IDLE) && (pending_q != 8'd0)) ? (8'b1 << sel) : 8'd0;

  // A rise landing on the bit IDLE is clearing wins (set beats clear) and is
  // not a drop; only a rise onto a still-pending bit is lost.
  assign pending_d = (pending_q & ~clr_mask) | rise;
  assign dropped_d = |(rise & pending_q & ~clr_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 8'd0;
      sync2_q   <= 8'd0;
      cnt_q     <= 24'd0;
      pressed_q <= 8'd0;
      prev_q    <= 8'd0;
      pending_q <= 8'd0;
      dropped_q <= 1'b0;
      for (int i = 0; i < 8; i++) dc_q[i] <= 2'd0;
    end else begin
      sync1_q   <= buttons;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      prev_q    <= pressed_q;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      for (int i = 0; i < 8; i++) dc_q[i] <= dc_d[i];
    end
  end

  // Command FSM with registered valid/code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q != 8'd0) begin
            code_q  <= sel;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (cmd.cmd_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pressed       = pressed_q;
  assign dropped       = dropped_q;
  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_code  = code_q;

endmodule

// File: tb/tb_action_input.sv
module tb_action_input;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] buttons;
  logic       ready;
  logic [7:0] pressed;
  logic       dropped;

  action_input_if cmd_bus ();
  assign cmd_bus.cmd_ready = ready;

  action_input #(.DEBOUNCE_COUNT(24'd4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .buttons (buttons),
    .pressed (pressed),
    .dropped (dropped),
    .cmd     (cmd_bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: levels after a 2-edge synchronizer, a count of
  // consecutive disagreeing sample ticks per action, a set of pending
  // actions, and a single "offer in progress" flag with its action index.
  bit [7:0] m_s1, m_sync, m_lvl, m_prev;
  int       m_dis [8];
  int       m_cnt;
  bit       m_pend [8];
  bit       m_off;
  int       m_code;
  bit       m_drop;

  int dut_acc [$];
  int n_drop;
  int vld_cycles;

  task automatic model_reset();
    m_s1 = 0; m_sync = 0; m_lvl = 0; m_prev = 0;
    m_cnt = 0; m_off = 0; m_code = 0; m_drop = 0;
    for (int i = 0; i < 8; i++) begin m_dis[i] = 0; m_pend[i] = 0; end
  endtask

  task automatic model_step();
    bit       tick;
    bit [7:0] rise;
    int       k;
    tick   = (m_cnt == N - 1);
    rise   = m_lvl & ~m_prev;
    m_prev = m_lvl;
    m_cnt  = (m_cnt + 1) % N;
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (m_sync[i] != m_lvl[i]) begin
          m_dis[i]++;
          if (m_dis[i] == 3) begin
            m_lvl[i] = ~m_lvl[i];
            m_dis[i] = 0;
          end
        end else begin
          m_dis[i] = 0;
        end
      end
    end
    if (!m_off) begin
      k = -1;
      for (int i = 0; i < 8; i++) if (k < 0 && m_pend[i]) k = i;
      if (k >= 0) begin
        m_off     = 1;
        m_code    = k;
        m_pend[k] = 0;
      end
    end else if (ready) begin
      m_off = 0;
    end
    m_drop = 0;
    for (int i = 0; i < 8; i++) begin
      if (rise[i]) begin
        if (m_pend[i]) m_drop = 1;
        m_pend[i] = 1;
      end
    end
    m_sync = m_s1;
    m_s1   = buttons;
  endtask

  task automatic step();
    if (cmd_bus.cmd_valid === 1'b1 && ready) dut_acc.push_back(int'(cmd_bus.cmd_code));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pressed", 32'(pressed), 32'(m_lvl));
    chk("valid", 32'(cmd_bus.cmd_valid), 32'(m_off));
    if (m_off) chk("code", 32'(cmd_bus.cmd_code), 32'(m_code));
    chk("dropped", 32'(dropped), 32'(m_drop));
    if (dropped === 1'b1) n_drop++;
    if (cmd_bus.cmd_valid === 1'b1) vld_cycles++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (cmd_bus.cmd_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk("wait_valid_timeout", 32'(n < max), 32'd1);
  endtask

  task automatic clear_stats();
    dut_acc.delete();
    n_drop     = 0;
    vld_cycles = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int code0_cycles;
    bit [7:0] seen;

    rst_n   = 1'b0;
    buttons = 8'd0;
    ready   = 1'b0;
    model_reset();
    clear_stats();
    repeat (2) @(negedge clk);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_valid", 32'(cmd_bus.cmd_valid), 32'd0);
    chk("rst_code", 32'(cmd_bus.cmd_code), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of an offer.
    buttons = 8'h10;
    wait_valid(40, n);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pressed", 32'(pressed), 32'd0);
    chk("midrst_valid", 32'(cmd_bus.cmd_valid), 32'd0);
    chk("midrst_code", 32'(cmd_bus.cmd_code), 32'd0);
    chk("midrst_dropped", 32'(dropped), 32'd0);
    buttons = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    ready = 1'b1;
    steps(40);
    chk("midrst_no_cmd", 32'(vld_cycles), 32'd0);

    // Single press with a ready consumer.
    clear_stats();
    buttons = 8'h04;
    n = 0;
    while (pressed[2] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("press_latency_in_range", 32'(n >= 11 && n <= 14), 32'd1);
    step();
    chk("press_edge1_valid", 32'(cmd_bus.cmd_valid), 32'd0);
    step();
    chk("press_edge2_valid", 32'(cmd_bus.cmd_valid), 32'd1);
    chk("press_edge2_code", 32'(cmd_bus.cmd_code), 32'd2);
    step();
    chk("press_one_cycle", 32'(cmd_bus.cmd_valid), 32'd0);
    if (n + 3 < 20) steps(20 - n - 3);
    buttons = 8'd0;
    steps(30);
    chk("press_cmd_count", 32'(dut_acc.size()), 32'd1);
    chk("press_valid_cycles", 32'(vld_cycles), 32'd1);

    // Glitch rejection: 7-cycle pulse.
    clear_stats();
    seen = 8'd0;
    buttons = 8'h20;
    for (int i = 0; i < 7; i++) begin step(); seen |= pressed; end
    buttons = 8'd0;
    for (int i = 0; i < 30; i++) begin step(); seen |= pressed; end
    chk("glitch_pressed", 32'(seen), 32'd0);
    chk("glitch_valid", 32'(vld_cycles), 32'd0);

    // Backpressure and priority.
    clear_stats();
    ready   = 1'b0;
    buttons = 8'h81;
    wait_valid(40, n);
    chk("prio_first_code", 32'(cmd_bus.cmd_code), 32'd0);
    code0_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cmd_bus.cmd_valid === 1'b1 && cmd_bus.cmd_code === 3'd0) code0_cycles++;
    end
    chk("prio_hold_cycles", 32'(code0_cycles), 32'd10);
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    chk("prio_next_valid", 32'(cmd_bus.cmd_valid), 32'd1);
    chk("prio_next_code", 32'(cmd_bus.cmd_code), 32'd7);
    ready   = 1'b1;
    buttons = 8'd0;
    steps(40);

    // Drop: action 1 pressed twice while action 3 is stuck in offer.
    clear_stats();
    ready   = 1'b0;
    buttons = 8'h08;
    wait_valid(40, n);
    chk("drop_offer_code", 32'(cmd_bus.cmd_code), 32'd3);
    buttons = 8'h02; steps(20);
    buttons = 8'h00; steps(20);
    buttons = 8'h02; steps(20);
    buttons = 8'h00; steps(20);
    chk("drop_pulses", 32'(n_drop), 32'd1);
    ready = 1'b1;
    steps(20);
    chk("drop_cmd_count", 32'(dut_acc.size()), 32'd2);
    if (dut_acc.size() == 2) begin
      chk("drop_cmd0", 32'(dut_acc[0]), 32'd3);
      chk("drop_cmd1", 32'(dut_acc[1]), 32'd1);
    end

    // Bounce on action 0, then a steady hold.
    clear_stats();
    buttons = 8'd0;
    for (int i = 0; i < 10; i++) begin
      buttons[0] = ~buttons[0];
      steps(3);
    end
    buttons = 8'h01;
    steps(40);
    chk("bounce_cmd_count", 32'(dut_acc.size()), 32'd1);
    if (dut_acc.size() == 1) chk("bounce_cmd_code", 32'(dut_acc[0]), 32'd0);
    buttons = 8'd0;
    steps(30);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 150; c++) begin
      buttons = buttons ^ 8'(1 << $urandom_range(0, 7));
      n = $urandom_range(1, 30);
      for (int j = 0; j < n; j++) begin
        ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
